fir_packet_sequencer: RTL and testbench

Parametrised packet sequencer between the data SPI slave and the FIR filter core. Generalised in sample widths, sample count and result pipeline depth. It unpacks received packets into filter sample vectors and launches the filter. It captures accumulator results with optional saturation and presents them to the SPI transmit path after a configurable packet latency. It also flags overruns when packets arrive faster than the filter completes.

---
 rtl/fir_packet_sequencer.sv | 148 ++++++++++++++
 tb/tb_fir_packet_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fir_packet_sequencer.sv
// Packet sequencer between the data SPI slave and the FIR core: unpacks samples, launches the filter,
// captures results into a TX pipeline and flags overruns. Define FIR_PKT_SATURATE_EN to clamp results.
module fir_packet_sequencer #(
    parameter int SAMPLES_NUM = 8,
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 32,
    parameter int ACC_WIDTH   = 40,
    parameter int TX_STAGES   = 1,
    localparam int PACKET_BITS = SAMPLES_NUM * OUT_WIDTH
) (
    input  logic                             clk,
    input  logic                             nResetIn,
    input  logic                             rxValidIn,
    input  logic [PACKET_BITS-1:0]           rxDataIn,
    output logic                             startOut,
    output logic [SAMPLES_NUM*IN_WIDTH-1:0]  samplesOut,
    input  logic                             doneIn,
    input  logic [SAMPLES_NUM*ACC_WIDTH-1:0] resultIn,
    output logic [PACKET_BITS-1:0]           txDataOut,
    output logic                             overrunOut,
    input  logic                             clearIn,
    output logic                             busyOut,
    output logic [15:0]                      packetCountOut
);

    localparam int USED_RX_BITS = SAMPLES_NUM * IN_WIDTH;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t                    state, stateNext;
    logic                      acceptEn, dropEn, captureEn;
    logic [USED_RX_BITS-1:0]   rxSamples;
    logic [PACKET_BITS-1:0]    capWord;
    logic [PACKET_BITS-1:0]    resultReg;
    logic [PACKET_BITS-1:0]    txPipe [TX_STAGES];
    logic [USED_RX_BITS-1:0]   samplesReg;
    logic [15:0]               packetCount;
    logic                      overrun;

`ifdef FIR_PKT_SATURATE_EN
    function automatic logic [OUT_WIDTH-1:0] satAcc(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0] maxVal;
        logic signed [ACC_WIDTH-1:0] minVal;
        maxVal = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        minVal = ~maxVal;
        if (acc > maxVal)
            satAcc = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (acc < minVal)
            satAcc = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            satAcc = acc[OUT_WIDTH-1:0];
    endfunction
`endif

    // Sample k sits at the MSB end of the packet but at the LSB end of the filter vector.
    for (genvar k = 0; k < SAMPLES_NUM; k++) begin : gLane
        assign rxSamples[IN_WIDTH*k +: IN_WIDTH] = rxDataIn[PACKET_BITS-1-IN_WIDTH*k -: IN_WIDTH];
`ifdef FIR_PKT_SATURATE_EN
        assign capWord[PACKET_BITS-1-OUT_WIDTH*k -: OUT_WIDTH] = satAcc(resultIn[ACC_WIDTH*k +: ACC_WIDTH]);
`else
        assign capWord[PACKET_BITS-1-OUT_WIDTH*k -: OUT_WIDTH] = resultIn[ACC_WIDTH*k +: OUT_WIDTH];
        if (ACC_WIDTH > OUT_WIDTH) begin : gTrunc
            logic unusedAccBits;
            assign unusedAccBits = ^resultIn[ACC_WIDTH*k+OUT_WIDTH +: ACC_WIDTH-OUT_WIDTH];
        end
`endif
    end

    if (PACKET_BITS > USED_RX_BITS) begin : gRxPad
        logic unusedRxBits;
        assign unusedRxBits = ^rxDataIn[PACKET_BITS-USED_RX_BITS-1:0];
    end

    always_comb begin
        stateNext = state;
        acceptEn  = 1'b0;
        dropEn    = 1'b0;
        captureEn = 1'b0;
        case (state)
            IDLE: begin
                if (rxValidIn) begin
                    acceptEn  = 1'b1;
                    stateNext = START;
                end
            end
            START: begin
                dropEn    = rxValidIn;
                stateNext = WAIT;
            end
            WAIT: begin
                if (doneIn) begin
                    captureEn = 1'b1;
                    if (rxValidIn) begin
                        acceptEn  = 1'b1;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    dropEn = rxValidIn;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nResetIn) begin
        if (!nResetIn) begin
            state       <= IDLE;
            samplesReg  <= '0;
            packetCount <= '0;
            overrun     <= 1'b0;
            resultReg   <= '0;
        end else begin
            state <= stateNext;
            if (acceptEn) begin
                samplesReg  <= rxSamples;
                packetCount <= packetCount + 16'd1;
            end
            if (dropEn)
                overrun <= 1'b1;
            else if (clearIn)
                overrun <= 1'b0;
            if (captureEn)
                resultReg <= capWord;
        end
    end

    // TX pipeline advances on every strobe; it sees resultReg before any same-edge capture.
    always_ff @(posedge clk or negedge nResetIn) begin
        if (!nResetIn) begin
            for (int i = 0; i < TX_STAGES; i++)
                txPipe[i] <= '0;
        end else if (rxValidIn) begin
            txPipe[0] <= resultReg;
            for (int i = 1; i < TX_STAGES; i++)
                txPipe[i] <= txPipe[i-1];
        end
    end

    assign startOut       = (state == START);
    assign busyOut        = (state != IDLE);
    assign samplesOut     = samplesReg;
    assign packetCountOut = packetCount;
    assign overrunOut     = overrun;
    assign txDataOut      = txPipe[TX_STAGES-1];

endmodule

// File: tb/tb_fir_packet_sequencer.sv
// Directed bench for fir_packet_sequencer: per-cycle vector table plus a reset-during-WAIT sequence.
module tb_fir_packet_sequencer;

    localparam int SN = 2, IW = 16, OW = 32, AW = 40, TS = 1;
    localparam int PB = SN * OW;

    logic             clk = 1'b0;
    logic             nResetIn = 1'b0;
    logic             rxValidIn = 1'b0;
    logic [PB-1:0]    rxDataIn = '0;
    logic             startOut;
    logic [SN*IW-1:0] samplesOut;
    logic             doneIn = 1'b0;
    logic [SN*AW-1:0] resultIn = '0;
    logic [PB-1:0]    txDataOut;
    logic             overrunOut;
    logic             clearIn = 1'b0;
    logic             busyOut;
    logic [15:0]      packetCountOut;

    fir_packet_sequencer #(
        .SAMPLES_NUM(SN), .IN_WIDTH(IW), .OUT_WIDTH(OW), .ACC_WIDTH(AW), .TX_STAGES(TS)
    ) dut (
        .clk(clk), .nResetIn(nResetIn), .rxValidIn(rxValidIn), .rxDataIn(rxDataIn),
        .startOut(startOut), .samplesOut(samplesOut), .doneIn(doneIn), .resultIn(resultIn),
        .txDataOut(txDataOut), .overrunOut(overrunOut), .clearIn(clearIn), .busyOut(busyOut),
        .packetCountOut(packetCountOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rx;
        logic [63:0] rxData;
        logic        done;
        logic [79:0] result;
        logic        clear;
        logic        eStart;
        logic [31:0] eSamples;
        logic [63:0] eTx;
        logic        eOverrun;
        logic        eBusy;
        logic [15:0] eCount;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int nApplied = 0;
    int nMiss = 0;

    function automatic vec_t mkVec(logic rx, logic [63:0] rxData, logic done, logic [79:0] result,
                                   logic clear, logic eStart, logic [31:0] eSamples,
                                   logic [63:0] eTx, logic eOverrun, logic eBusy, logic [15:0] eCount);
        vec_t v;
        v.rx = rx; v.rxData = rxData; v.done = done; v.result = result; v.clear = clear;
        v.eStart = eStart; v.eSamples = eSamples; v.eTx = eTx; v.eOverrun = eOverrun;
        v.eBusy = eBusy; v.eCount = eCount;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiss++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic eStart, input logic [31:0] eSamples,
                          input logic [63:0] eTx, input logic eOverrun, input logic eBusy,
                          input logic [15:0] eCount);
        chk({tag, ".start"},   64'(startOut),       64'(eStart));
        chk({tag, ".samples"}, 64'(samplesOut),     64'(eSamples));
        chk({tag, ".tx"},      txDataOut,           eTx);
        chk({tag, ".overrun"}, 64'(overrunOut),     64'(eOverrun));
        chk({tag, ".busy"},    64'(busyOut),        64'(eBusy));
        chk({tag, ".count"},   64'(packetCountOut), 64'(eCount));
    endtask

    localparam logic [79:0] R1 = {40'hFFFFFFFFFE, 40'h0000000005};
    localparam logic [79:0] R2 = {40'hFE00000000, 40'h0100000000};
    localparam logic [79:0] R3 = {40'h0000000003, 40'h0000000007};
    localparam logic [63:0] TX1 = 64'h00000005_FFFFFFFE;
    localparam logic [63:0] TX3 = 64'h00000007_00000003;
`ifdef FIR_PKT_SATURATE_EN
    localparam logic [63:0] SATV = 64'h7FFFFFFF_80000000;
`else
    localparam logic [63:0] SATV = 64'h00000000_00000000;
`endif

    initial begin
        //                 rx  rxData                 done result clr | start samples       tx    ovr busy count
        vecs[0]  = mkVec(1, 64'h1234ABCD_55556666, 0, '0, 0,   1, 32'hABCD1234, '0,   0, 1, 1);
        vecs[1]  = mkVec(0, '0,                    0, '0, 0,   0, 32'hABCD1234, '0,   0, 1, 1);
        vecs[2]  = mkVec(0, '0,                    0, '0, 0,   0, 32'hABCD1234, '0,   0, 1, 1);
        vecs[3]  = mkVec(1, 64'hDEADBEEF_00000000, 0, '0, 0,   0, 32'hABCD1234, '0,   1, 1, 1);
        vecs[4]  = mkVec(0, '0,                    0, '0, 1,   0, 32'hABCD1234, '0,   0, 1, 1);
        vecs[5]  = mkVec(1, 64'hCAFEF00D_00000000, 0, '0, 1,   0, 32'hABCD1234, '0,   1, 1, 1);
        vecs[6]  = mkVec(0, '0,                    0, '0, 1,   0, 32'hABCD1234, '0,   0, 1, 1);
        vecs[7]  = mkVec(0, '0,                    1, R1, 0,   0, 32'hABCD1234, '0,   0, 0, 1);
        vecs[8]  = mkVec(1, 64'h11112222_00000000, 0, '0, 0,   1, 32'h22221111, TX1,  0, 1, 2);
        vecs[9]  = mkVec(0, '0,                    0, '0, 0,   0, 32'h22221111, TX1,  0, 1, 2);
        vecs[10] = mkVec(1, 64'h33334444_00000000, 1, R2, 0,   1, 32'h44443333, TX1,  0, 1, 3);
        vecs[11] = mkVec(1, 64'h77778888_00000000, 0, '0, 0,   0, 32'h44443333, SATV, 1, 1, 3);
        vecs[12] = mkVec(0, '0,                    1, R3, 1,   0, 32'h44443333, SATV, 0, 0, 3);
        vecs[13] = mkVec(1, 64'h55556666_00000000, 0, '0, 0,   1, 32'h66665555, TX3,  0, 1, 4);
        vecs[14] = mkVec(1, 64'h99990000_00000000, 0, '0, 0,   0, 32'h66665555, TX3,  1, 1, 4);

        repeat (2) @(negedge clk);
        chkAll("reset", 0, '0, '0, 0, 0, 16'd0);
        nResetIn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rxValidIn = vecs[i].rx;
            rxDataIn  = vecs[i].rxData;
            doneIn    = vecs[i].done;
            resultIn  = vecs[i].result;
            clearIn   = vecs[i].clear;
            @(posedge clk);
            #1;
            chkAll($sformatf("vec%0d", i), vecs[i].eStart, vecs[i].eSamples, vecs[i].eTx,
                   vecs[i].eOverrun, vecs[i].eBusy, vecs[i].eCount);
        end

        // Reset while WAITing: outputs clear without a clock edge, later doneIn must not capture.
        @(negedge clk);
        rxValidIn = 1'b0; doneIn = 1'b0; clearIn = 1'b0;
        #2 nResetIn = 1'b0;
        #1 chkAll("asyncRst", 0, '0, '0, 0, 0, 16'd0);
        @(negedge clk);
        nResetIn = 1'b1;
        @(negedge clk);
        doneIn = 1'b1; resultIn = R1;
        @(posedge clk);
        #1 chkAll("lateDone", 0, '0, '0, 0, 0, 16'd0);
        @(negedge clk);
        doneIn = 1'b0; rxValidIn = 1'b1; rxDataIn = 64'h9999AAAA_00000000;
        @(posedge clk);
        #1 chkAll("postRst", 1, 32'hAAAA9999, '0, 0, 1, 16'd1);
        @(negedge clk);
        rxValidIn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
        $finish;
    end

endmodule
